// File: rtl/four_bank_mem_pkg.sv
// Shared constants and helpers for the four-bank interleaved main memory.
package four_bank_mem_pkg;
    localparam int NUM_BANKS     = 4;
    localparam int BANK_W        = 2;
    localparam int WORD_W        = 16;
    localparam int ADDR_W        = 16;
    localparam int CNT_W         = 3;
    localparam int DEF_ROWS      = 256;
    localparam int DEF_BANK_BUSY = 4;
    localparam int DEF_READ_LAT  = 2;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[2:1];
    endfunction
endpackage

// File: rtl/four_bank_mem_bank.sv
// One storage bank: ROWS x 16 array, occupancy counter and first read stage.
module mem_bank
    import four_bank_mem_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int BANK_BUSY = DEF_BANK_BUSY,
    localparam int ROW_W    = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              rd,
    input  logic              wr,
    input  logic [ROW_W-1:0]  row,
    input  logic [WORD_W-1:0] wdata,
    input  logic              clr_en,
    input  logic [ROW_W-1:0]  clr_row,
    output logic              busy,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data
);
    logic [WORD_W-1:0] mem_q [ROWS];
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              busy_d, busy_q;
    logic              rd_valid_d, rd_valid_q;
    logic [WORD_W-1:0] rd_data_d, rd_data_q;

    // Storage array; the clear sweep and normal accepts never coincide.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_row] <= '0;
        end else if (accept && wr) begin
            mem_q[row] <= wdata;
        end
    end

    // Next-state for occupancy counter and read stage 1.
    always_comb begin
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (rst) begin
            cnt_d     = '0;
            rd_data_d = '0;
        end else if (accept) begin
            cnt_d      = CNT_W'(BANK_BUSY - 1);
            rd_valid_d = rd;
            rd_data_d  = rd ? mem_q[row] : rd_data_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        busy_d = (cnt_d != '0);
    end

    // Counter, busy flag and read stage registers.
    always_ff @(posedge clk) begin
        cnt_q      <= cnt_d;
        busy_q     <= busy_d;
        rd_valid_q <= rd_valid_d;
        rd_data_q  <= rd_data_d;
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
endmodule

// File: rtl/four_bank_mem.sv
// Four-bank interleaved memory responder with 2-cycle read latency.
// Optional post-reset zero sweep of all rows: MEM_CLEAR_ON_RST_EN.
module four_bank_mem
    import four_bank_mem_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int BANK_BUSY = DEF_BANK_BUSY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);
    localparam int ROW_W = $clog2(ROWS);

    logic                 req_s, illegal_s, legal_s, accept_s;
    logic [BANK_W-1:0]    bank_s;
    logic [ROW_W-1:0]     row_s;
    logic [NUM_BANKS-1:0] bank_busy_s, busy_all_s, bank_acc_s, rd_valid_s;
    logic [WORD_W-1:0]    rd_data_s [NUM_BANKS];
    logic [WORD_W-1:0]    data_out_d, data_out_q;
    logic                 sweep_s;
    logic [ROW_W-1:0]     clr_row_s;

`ifdef MEM_CLEAR_ON_RST_EN
    logic             sweep_d, sweep_q;
    logic [ROW_W-1:0] sweep_row_d, sweep_row_q;

    // Sweep restarts on every reset cycle and ends after the last row.
    always_comb begin
        sweep_d     = sweep_q;
        sweep_row_d = sweep_row_q;
        if (rst) begin
            sweep_d     = 1'b1;
            sweep_row_d = '0;
        end else if (sweep_q) begin
            if (sweep_row_q == ROW_W'(ROWS - 1)) begin
                sweep_d = 1'b0;
            end else begin
                sweep_row_d = sweep_row_q + ROW_W'(1);
            end
        end else begin
            sweep_d = 1'b0;
        end
    end

    // Sweep state registers.
    always_ff @(posedge clk) begin
        sweep_q     <= sweep_d;
        sweep_row_q <= sweep_row_d;
    end

    assign sweep_s   = sweep_q & ~rst;
    assign clr_row_s = sweep_row_q;
`else
    assign sweep_s   = 1'b0;
    assign clr_row_s = '0;
`endif

    // Request decode, legality, back-pressure and per-bank accept.
    always_comb begin
        req_s      = rd | wr;
        illegal_s  = (rd & wr) | (req_s & addr[0]);
        legal_s    = req_s & ~illegal_s & ~rst;
        bank_s     = bank_of(addr);
        row_s      = addr[ROW_W+2:3];
        busy_all_s = bank_busy_s | {NUM_BANKS{sweep_s}};
        stall      = legal_s & busy_all_s[bank_s];
        err        = illegal_s & ~rst;
        accept_s   = legal_s & ~busy_all_s[bank_s];
        bank_acc_s = '0;
        if (accept_s) begin
            bank_acc_s[bank_s] = 1'b1;
        end else begin
            bank_acc_s = '0;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .ROWS      (ROWS),
            .BANK_BUSY (BANK_BUSY)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .accept   (bank_acc_s[b]),
            .rd       (rd),
            .wr       (wr),
            .row      (row_s),
            .wdata    (data_in),
            .clr_en   (sweep_s),
            .clr_row  (clr_row_s),
            .busy     (bank_busy_s[b]),
            .rd_valid (rd_valid_s[b]),
            .rd_data  (rd_data_s[b])
        );
    end

    // At most one bank has stage-1 data valid, so an OR-mux suffices.
    always_comb begin
        data_out_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_valid_s[b]) begin
                data_out_d = data_out_d | rd_data_s[b];
            end else begin
                data_out_d = data_out_d;
            end
        end
        if (rst) begin
            data_out_d = '0;
        end else begin
            data_out_d = data_out_d;
        end
    end

    // Output data register.
    always_ff @(posedge clk) begin
        data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
    assign busy     = busy_all_s;
endmodule
